// File: rtl/pwm_deadtime_gen_if.sv
// Config, PWM input and drive outputs of the dead-time stage.
// The SFR/generator side uses master; the dead-time block uses slave.
interface pwm_deadtime_gen_if #(
  parameter int unsigned N = 16
);
  logic         sys_clk_en;
  logic         pwm_in;
  logic [N-1:0] dt_rise;
  logic [N-1:0] dt_fall;
  logic         pol_h;
  logic         pol_l;
  logic         out_en;
  logic         fault_in;
  logic         fault_clr;
  logic         pwm_h;
  logic         pwm_l;
  logic         dt_active;
  logic         fault_flag;

  modport master (
    output sys_clk_en, pwm_in, dt_rise, dt_fall, pol_h, pol_l, out_en,
           fault_in, fault_clr,
    input  pwm_h, pwm_l, dt_active, fault_flag
  );

  modport slave (
    input  sys_clk_en, pwm_in, dt_rise, dt_fall, pol_h, pol_l, out_en,
           fault_in, fault_clr,
    output pwm_h, pwm_l, dt_active, fault_flag
  );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low-side PWM pair with independent rise/fall dead time
// and a sticky synchronous fault shutdown.
module pwm_deadtime_gen #(
  parameter int unsigned N = 16
) (
  input logic              sys_clk,
  input logic              sys_rst,
  pwm_deadtime_gen_if.slave bus
);

  typedef enum logic [4:0] {
    S_LOW  = 5'b00001,
    S_DTR  = 5'b00010,
    S_HIGH = 5'b00100,
    S_DTF  = 5'b01000,
    S_FLT  = 5'b10000
  } state_t;

  state_t       state, state_d;
  logic [N-1:0] dt_cnt, cnt_d;
  logic         pwm_in_q;
  logic         fault_flag, flag_d;
  logic         h_raw, l_raw;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_DTF;
      dt_cnt     <= '0;
      pwm_in_q   <= 1'b0;
      fault_flag <= 1'b0;
    end else begin
      // state/count/flag hold via next-state defaults, so fault can act while disabled
      state      <= state_d;
      dt_cnt     <= cnt_d;
      fault_flag <= flag_d;
      if (bus.sys_clk_en) pwm_in_q <= bus.pwm_in;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = dt_cnt;
    flag_d  = fault_flag;
    if (bus.fault_in) begin
      state_d = S_FLT;
      flag_d  = 1'b1;
    end else if (bus.sys_clk_en) begin
      case (state)
        S_LOW: begin
          if (pwm_in_q) begin
            state_d = (bus.dt_rise == '0) ? S_HIGH : S_DTR;
            cnt_d   = bus.dt_rise - N'(1);
          end
        end
        S_DTR: begin
          if (!pwm_in_q)         state_d = S_LOW;
          else if (dt_cnt == '0) state_d = S_HIGH;
          else                   cnt_d   = dt_cnt - N'(1);
        end
        S_HIGH: begin
          if (!pwm_in_q) begin
            state_d = (bus.dt_fall == '0) ? S_LOW : S_DTF;
            cnt_d   = bus.dt_fall - N'(1);
          end
        end
        S_DTF: begin
          if (pwm_in_q)          state_d = S_HIGH;
          else if (dt_cnt == '0) state_d = S_LOW;
          else                   cnt_d   = dt_cnt - N'(1);
        end
        S_FLT: begin
          if (bus.fault_clr) begin
            state_d = (bus.dt_fall == '0) ? S_LOW : S_DTF;
            cnt_d   = bus.dt_fall - N'(1);
            flag_d  = 1'b0;
          end
        end
        default: state_d = S_LOW;
      endcase
    end
  end

  // One-hot bits feed the pins directly so the raw drives never glitch
  assign h_raw = state[2];
  assign l_raw = state[0];

  assign bus.pwm_h      = (h_raw ^ bus.pol_h) & bus.out_en;
  assign bus.pwm_l      = (l_raw ^ bus.pol_l) & bus.out_en;
  assign bus.dt_active  = state[1] | state[3];
  assign bus.fault_flag = fault_flag;

endmodule
